// File: rtl/spi_slave_periph_pkg.sv
// Shared constants and types for the SPI slave peripheral and the MCU SPI driver.
package spi_slave_periph_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned CNT_W  = 3;

    // Register byte offsets on the CPU data bus
    localparam int unsigned SPI_DATA_OFF   = 0;
    localparam int unsigned SPI_STATUS_OFF = 4;

    // STATUS register bit positions
    localparam int unsigned SPI_RDY_BIT  = 0;
    localparam int unsigned SPI_BUSY_BIT = 1;
    localparam int unsigned SPI_OVR_BIT  = 2;
    localparam int unsigned SPI_IE_BIT   = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchroniser plus registered level/rise/fall detect for one asynchronous bit.
module spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic level_q;
    logic rise_q;
    logic fall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q  <= RST_VAL;
            sync_q  <= RST_VAL;
            level_q <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            meta_q  <= d_i;
            sync_q  <= meta_q;
            level_q <= sync_q;
            rise_q  <= sync_q & ~level_q;
            fall_q  <= ~sync_q & level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/spi_slave_periph.sv
// Memory-mapped SPI mode-0 slave with DATA/STATUS registers.
// Optional interrupt output enabled by SPI_SLAVE_PERIPH_IRQ_EN.
module spi_slave_periph
    import spi_slave_periph_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic              re,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd,
    input  logic              sck,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso
`ifdef SPI_SLAVE_PERIPH_IRQ_EN
    ,
    output logic              irq
`endif
);

    logic sck_rise, sck_fall, ss_rise, ss_fall, mosi_lvl;
    logic unused_sck_lvl, unused_ss_lvl, unused_mosi_rise, unused_mosi_fall;
    logic unused_c;

    spi_sync #(.RST_VAL(1'b0)) u_sync_sck (
        .clk_i(clk), .rst_i(rst), .d_i(sck),
        .level_o(unused_sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    // ss resets low so a frame held across reset is ignored until the next falling edge
    spi_sync #(.RST_VAL(1'b0)) u_sync_ss (
        .clk_i(clk), .rst_i(rst), .d_i(ss),
        .level_o(unused_ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall)
    );

    spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk_i(clk), .rst_i(rst), .d_i(mosi),
        .level_o(mosi_lvl), .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
    );

    assign unused_c = ^{addr[1:0], wd[DATA_W-1:BYTE_W]};

    spi_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BYTE_W-1:0]   rx_sh_q, rx_sh_d;
    logic [BYTE_W-1:0]   tx_sh_q, tx_sh_d;
    logic [BYTE_W-1:0]   rx_data_q, rx_data_d;
    logic [BYTE_W-1:0]   hold_q, hold_d;
    logic                rdy_q, rdy_d;
    logic                ovr_q, ovr_d;
    logic                miso_q, miso_d;
    logic [BYTE_W-1:0]   byte_c;
    logic                data_sel_c, stat_sel_c;
    logic                data_rd_c, data_wr_c, stat_wr_c;
    logic [DATA_W-1:0]   status_c;
`ifdef SPI_SLAVE_PERIPH_IRQ_EN
    logic                ie_q, ie_d;
    logic                irq_q;
`endif

    assign data_sel_c = (addr[2] == 1'(SPI_DATA_OFF >> 2));
    assign stat_sel_c = (addr[2] == 1'(SPI_STATUS_OFF >> 2));
    assign data_rd_c  = re & data_sel_c;
    assign data_wr_c  = we & data_sel_c;
    assign stat_wr_c  = we & stat_sel_c;
    assign byte_c     = {rx_sh_q[BYTE_W-2:0], mosi_lvl};

    // Frame FSM and register next-state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rx_sh_d   = rx_sh_q;
        tx_sh_d   = tx_sh_q;
        rx_data_d = rx_data_q;
        hold_d    = hold_q;
        rdy_d     = rdy_q;
        ovr_d     = ovr_q;
`ifdef SPI_SLAVE_PERIPH_IRQ_EN
        ie_d      = ie_q;
        if (stat_wr_c) ie_d = wd[SPI_IE_BIT];
`endif
        if (data_wr_c) hold_d = wd[BYTE_W-1:0];
        if (data_rd_c) rdy_d = 1'b0;
        if (stat_wr_c && wd[SPI_OVR_BIT]) ovr_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    tx_sh_d = hold_d;
                end
            end
            ST_SHIFT: begin
                if (ss_rise) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (sck_rise) begin
                    rx_sh_d = byte_c;
                    if (cnt_q == CNT_W'(BYTE_W - 1)) begin
                        cnt_d   = '0;
                        tx_sh_d = hold_d;
                        // A read in the completion cycle frees the slot for the new byte
                        if (!rdy_q || data_rd_c) begin
                            rx_data_d = byte_c;
                            rdy_d     = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (sck_fall && (cnt_q != '0)) begin
                    tx_sh_d = {tx_sh_q[BYTE_W-2:0], 1'b0};
                end
            end
            default: state_d = ST_IDLE;
        endcase

        miso_d = (state_d == ST_SHIFT) & tx_sh_d[BYTE_W-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rx_sh_q   <= '0;
            tx_sh_q   <= '0;
            rx_data_q <= '0;
            hold_q    <= '0;
            rdy_q     <= 1'b0;
            ovr_q     <= 1'b0;
            miso_q    <= 1'b0;
`ifdef SPI_SLAVE_PERIPH_IRQ_EN
            ie_q      <= 1'b0;
            irq_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rx_sh_q   <= rx_sh_d;
            tx_sh_q   <= tx_sh_d;
            rx_data_q <= rx_data_d;
            hold_q    <= hold_d;
            rdy_q     <= rdy_d;
            ovr_q     <= ovr_d;
            miso_q    <= miso_d;
`ifdef SPI_SLAVE_PERIPH_IRQ_EN
            ie_q      <= ie_d;
            irq_q     <= ie_q & (rdy_q | ovr_q);
`endif
        end
    end

    always_comb begin
        status_c               = '0;
        status_c[SPI_RDY_BIT]  = rdy_q;
        status_c[SPI_BUSY_BIT] = (state_q == ST_SHIFT);
        status_c[SPI_OVR_BIT]  = ovr_q;
`ifdef SPI_SLAVE_PERIPH_IRQ_EN
        status_c[SPI_IE_BIT]   = ie_q;
`else
        status_c[SPI_IE_BIT]   = 1'b0;
`endif
    end

    assign rd   = data_sel_c ? DATA_W'(rx_data_q) : status_c;
    assign miso = miso_q;
`ifdef SPI_SLAVE_PERIPH_IRQ_EN
    assign irq  = irq_q;
`endif

endmodule

// File: tb/tb_spi_slave_periph.sv
// Self-checking bench for spi_slave_periph; the bench acts as the SPI master (mode 0, sck period 8 clk).
module tb_spi_slave_periph;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  addr = 3'd0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] wd = 32'd0;
    logic [31:0] rd;
    logic        sck = 1'b0;
    logic        ss = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
`ifdef SPI_SLAVE_PERIPH_IRQ_EN
    logic        irq;
`endif

    int unsigned tot_cnt = 0;
    int unsigned pass_cnt = 0;
    logic [7:0]  exp_rx[$];
    logic [7:0]  exp_miso[$];

    spi_slave_periph dut (
        .clk(clk), .rst(rst), .addr(addr), .we(we), .re(re), .wd(wd), .rd(rd),
        .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
`ifdef SPI_SLAVE_PERIPH_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, tot_cnt);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        addr = a; wd = d; we = 1'b1;
        tick(1);
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic do_re, output logic [31:0] d);
        addr = a; re = do_re;
        #1 d = rd;
        tick(1);
        re = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic ss_low();
        ss = 1'b0;
        tick(6);
    endtask

    task automatic ss_high();
        tick(2);
        ss = 1'b1;
        tick(6);
    endtask

    // Shifts nbits of txb MSB-first; collide issues a DATA read in the cycle the 8th bit lands.
    task automatic spi_xfer(input logic [7:0] txb, input int nbits, input bit collide,
                            output logic [7:0] rxb, output logic [31:0] coll_rd);
        rxb = 8'd0;
        coll_rd = 32'd0;
        for (int i = 0; i < nbits; i++) begin
            mosi = txb[7-i];
            tick(4);
            sck = 1'b1;
            rxb = {rxb[6:0], miso};
            for (int k = 0; k < 4; k++) begin
                tick(1);
                if (collide && i == 7) begin
                    if (k == 2) begin
                        addr = 3'd0; re = 1'b1;
                        #1 coll_rd = rd;
                    end else if (k == 3) begin
                        re = 1'b0;
                    end
                end
            end
            sck = 1'b0;
        end
        tick(4);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        pulse_reset();
        bus_read(3'd0, 1'b0, d);
        tot_cnt++; if (d !== 32'h0) $display("FAIL reset_data: got %h expected %h", d, 32'h0); else pass_cnt++;
        bus_read(3'd4, 1'b0, d);
        tot_cnt++; if (d !== 32'h0) $display("FAIL reset_status: got %h expected %h", d, 32'h0); else pass_cnt++;
        tot_cnt++; if (miso !== 1'b0) $display("FAIL reset_miso: got %b expected 0", miso); else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [7:0] r, e;
        logic [31:0] d, c;
        bus_write(3'd0, 32'h0000_00aa);
        exp_miso.push_back(8'haa);
        exp_rx.push_back(8'hde);
        ss_low();
        bus_read(3'd4, 1'b0, d);
        tot_cnt++; if (d !== 32'h2) $display("FAIL basic_status_start: got %h expected %h", d, 32'h2); else pass_cnt++;
        spi_xfer(8'hde, 8, 1'b0, r, c);
        e = exp_miso.pop_front();
        tot_cnt++; if (r !== e) $display("FAIL basic_miso_byte: got %h expected %h", r, e); else pass_cnt++;
        bus_read(3'd4, 1'b0, d);
        tot_cnt++; if (d !== 32'h3) $display("FAIL basic_status_frame: got %h expected %h", d, 32'h3); else pass_cnt++;
        tot_cnt++; if (miso !== 1'b1) $display("FAIL basic_miso_reload: got %b expected 1", miso); else pass_cnt++;
        ss_high();
        tot_cnt++; if (miso !== 1'b0) $display("FAIL basic_miso_idle: got %b expected 0", miso); else pass_cnt++;
        bus_read(3'd4, 1'b0, d);
        tot_cnt++; if (d !== 32'h1) $display("FAIL basic_status_idle: got %h expected %h", d, 32'h1); else pass_cnt++;
        bus_read(3'd0, 1'b1, d);
        e = exp_rx.pop_front();
        tot_cnt++; if (d !== {24'd0, e}) $display("FAIL basic_data: got %h expected %h", d, {24'd0, e}); else pass_cnt++;
        bus_read(3'd4, 1'b0, d);
        tot_cnt++; if (d !== 32'h0) $display("FAIL basic_rdy_clear: got %h expected %h", d, 32'h0); else pass_cnt++;
    endtask

    task automatic test_overrun();
        logic [7:0] r, e;
        logic [31:0] d, c;
        exp_rx.push_back(8'h12);
        exp_miso.push_back(8'haa);
        exp_miso.push_back(8'haa);
        ss_low();
        spi_xfer(8'h12, 8, 1'b0, r, c);
        e = exp_miso.pop_front();
        tot_cnt++; if (r !== e) $display("FAIL ovr_miso_byte0: got %h expected %h", r, e); else pass_cnt++;
        spi_xfer(8'h34, 8, 1'b0, r, c);
        e = exp_miso.pop_front();
        tot_cnt++; if (r !== e) $display("FAIL ovr_miso_byte1: got %h expected %h", r, e); else pass_cnt++;
        ss_high();
        bus_read(3'd4, 1'b0, d);
        tot_cnt++; if (d !== 32'h5) $display("FAIL ovr_status: got %h expected %h", d, 32'h5); else pass_cnt++;
        bus_read(3'd0, 1'b1, d);
        e = exp_rx.pop_front();
        tot_cnt++; if (d !== {24'd0, e}) $display("FAIL ovr_data: got %h expected %h", d, {24'd0, e}); else pass_cnt++;
        bus_write(3'd4, 32'h4);
        bus_read(3'd4, 1'b0, d);
        tot_cnt++; if (d !== 32'h0) $display("FAIL ovr_clear: got %h expected %h", d, 32'h0); else pass_cnt++;
    endtask

    task automatic test_abort();
        logic [7:0] r, e;
        logic [31:0] d, c;
        pulse_reset();
        ss_low();
        spi_xfer(8'hff, 5, 1'b0, r, c);
        ss_high();
        bus_read(3'd4, 1'b0, d);
        tot_cnt++; if (d !== 32'h0) $display("FAIL abort_status: got %h expected %h", d, 32'h0); else pass_cnt++;
        bus_read(3'd0, 1'b0, d);
        tot_cnt++; if (d !== 32'h0) $display("FAIL abort_data: got %h expected %h", d, 32'h0); else pass_cnt++;
        exp_rx.push_back(8'h5a);
        ss_low();
        spi_xfer(8'h5a, 8, 1'b0, r, c);
        ss_high();
        bus_read(3'd0, 1'b1, d);
        e = exp_rx.pop_front();
        tot_cnt++; if (d !== {24'd0, e}) $display("FAIL abort_next_byte: got %h expected %h", d, {24'd0, e}); else pass_cnt++;
    endtask

    task automatic test_back_to_back_read();
        logic [7:0] r, e;
        logic [31:0] d, c;
        exp_rx.push_back(8'h11);
        exp_rx.push_back(8'h22);
        ss_low();
        spi_xfer(8'h11, 8, 1'b0, r, c);
        spi_xfer(8'h22, 8, 1'b1, r, c);
        e = exp_rx.pop_front();
        tot_cnt++; if (c !== {24'd0, e}) $display("FAIL coll_read: got %h expected %h", c, {24'd0, e}); else pass_cnt++;
        bus_read(3'd4, 1'b0, d);
        tot_cnt++; if (d !== 32'h3) $display("FAIL coll_status: got %h expected %h", d, 32'h3); else pass_cnt++;
        ss_high();
        bus_read(3'd0, 1'b1, d);
        e = exp_rx.pop_front();
        tot_cnt++; if (d !== {24'd0, e}) $display("FAIL coll_next_data: got %h expected %h", d, {24'd0, e}); else pass_cnt++;
        bus_read(3'd4, 1'b0, d);
        tot_cnt++; if (d !== 32'h0) $display("FAIL coll_final_status: got %h expected %h", d, 32'h0); else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] r, e;
        logic [31:0] d, c;
        bus_write(3'd0, 32'hff);
        ss_low();
        spi_xfer(8'h0f, 4, 1'b0, r, c);
        pulse_reset();
        bus_read(3'd4, 1'b0, d);
        tot_cnt++; if (d !== 32'h0) $display("FAIL rstmid_status: got %h expected %h", d, 32'h0); else pass_cnt++;
        tot_cnt++; if (miso !== 1'b0) $display("FAIL rstmid_miso: got %b expected 0", miso); else pass_cnt++;
        ss_high();
        exp_rx.push_back(8'h81);
        exp_miso.push_back(8'h00);
        ss_low();
        spi_xfer(8'h81, 8, 1'b0, r, c);
        ss_high();
        e = exp_miso.pop_front();
        tot_cnt++; if (r !== e) $display("FAIL rstmid_miso_byte: got %h expected %h", r, e); else pass_cnt++;
        bus_read(3'd0, 1'b1, d);
        e = exp_rx.pop_front();
        tot_cnt++; if (d !== {24'd0, e}) $display("FAIL rstmid_data: got %h expected %h", d, {24'd0, e}); else pass_cnt++;
    endtask

    task automatic test_ie();
        logic [31:0] d, c, exp_st;
        logic [7:0] r, e;
`ifdef SPI_SLAVE_PERIPH_IRQ_EN
        exp_st = 32'h8;
`else
        exp_st = 32'h0;
`endif
        bus_write(3'd4, 32'h8);
        bus_read(3'd4, 1'b0, d);
        tot_cnt++; if (d !== exp_st) $display("FAIL ie_status: got %h expected %h", d, exp_st); else pass_cnt++;
`ifdef SPI_SLAVE_PERIPH_IRQ_EN
        tot_cnt++; if (irq !== 1'b0) $display("FAIL irq_idle: got %b expected 0", irq); else pass_cnt++;
        exp_rx.push_back(8'hc3);
        ss_low();
        spi_xfer(8'hc3, 8, 1'b0, r, c);
        ss_high();
        tot_cnt++; if (irq !== 1'b1) $display("FAIL irq_set: got %b expected 1", irq); else pass_cnt++;
        bus_read(3'd0, 1'b1, d);
        e = exp_rx.pop_front();
        tot_cnt++; if (d !== {24'd0, e}) $display("FAIL irq_data: got %h expected %h", d, {24'd0, e}); else pass_cnt++;
        tick(2);
        tot_cnt++; if (irq !== 1'b0) $display("FAIL irq_clear: got %b expected 0", irq); else pass_cnt++;
`else
        r = 8'd0; e = 8'd0; c = 32'd0;
`endif
        bus_write(3'd4, 32'h0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_abort();
        test_back_to_back_read();
        test_reset_mid_frame();
        test_ie();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
